// File: rtl/vblank_sync_gen_pkg.sv
// Shared types and constants for the vertical sync regenerator.
package vblank_sync_pkg;

    localparam int LINE_W     = 9;
    localparam int VBL_W      = 8;
    localparam int PAL_THRESH = 287;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        VS,
        DONE,
        FREE
    } state_t;

    // Start line of vsync inside vblank, centred on half the measured length.
    function automatic logic [VBL_W-1:0] calc_vs_start(
        input logic [VBL_W-1:0] len,
        input int unsigned      vs_lines,
        input int unsigned      vs_offset
    );
        int unsigned l;
        int unsigned half;
        l    = 32'(len);
        half = l >> 1;
        if ((l < vs_lines + 2) || (half < vs_offset)) begin
            return '0;
        end
        return VBL_W'(half - vs_offset);
    endfunction

endpackage

// File: rtl/vblank_sync_gen_line_strobe_det.sv
// Registers raw hsync once and flags the cycle of its rising edge.
module line_strobe_det (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_hs,
    output logic o_strobe,
    output logic o_hsync
);

    logic r_hs;

    // One-cycle delayed copy of hs_in; doubles as the mixer hsync.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hs <= 1'b0;
        end else begin
            r_hs <= i_hs;
        end
    end

    assign o_strobe = i_hs & ~r_hs;
    assign o_hsync  = r_hs;

endmodule

// File: rtl/vblank_sync_gen.sv
// Vertical sync regenerator: measures vblank, centres a fixed-width vsync in
// the next vblank, and free-runs vsync when vblank stops arriving.
// Optional frame statistics (frame_lines, pal_frame) under VBLANK_SYNC_STATS_EN.
module vblank_sync_gen
    import vblank_sync_pkg::*;
#(
    parameter int unsigned VS_LINES  = 4,
    parameter int unsigned VS_OFFSET = 10,
    parameter int unsigned DEF_START = 8,
    parameter int unsigned MAX_LINES = 400
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             hs_in,
    input  logic             vblank_in,
    output logic             hsync,
    output logic             vsync,
    output logic [VBL_W-1:0] vbl_len,
    output logic             sync_lost
`ifdef VBLANK_SYNC_STATS_EN
    ,
    output logic [LINE_W-1:0] frame_lines,
    output logic              pal_frame
`endif
);

    localparam logic [LINE_W-1:0] L_MAX       = LINE_W'(MAX_LINES);
    localparam logic [LINE_W-1:0] L_MAX_M1    = LINE_W'(MAX_LINES - 1);
    localparam logic [LINE_W-1:0] L_VS_LINES  = LINE_W'(VS_LINES);
    localparam logic [VBL_W-1:0]  L_DEF_START = VBL_W'(DEF_START);

    logic              w_strobe;
    logic              w_hsync;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_vbl_d;
    logic [VBL_W-1:0]  r_vblcnt;
    logic [VBL_W-1:0]  w_vblcnt_nxt;
    logic [VBL_W-1:0]  r_vbl_len;
    logic [VBL_W-1:0]  r_vs_start;
    logic [VBL_W-1:0]  w_vs_start;
    logic              r_valid;
    logic              r_upd;
    logic [LINE_W-1:0] r_line_cnt;
    logic [LINE_W-1:0] w_line_nxt;
    logic [LINE_W-1:0] w_line_inc;
    logic [LINE_W-1:0] w_free_phase;
    logic              w_timeout;
    logic [LINE_W-1:0] r_vs_cnt;
    logic [LINE_W-1:0] w_vs_cnt_nxt;
    logic              r_vsync;
    logic              w_vsync_nxt;
    logic              r_sync_lost;
    logic              w_rise;
    logic              w_fall;

    line_strobe_det u_strobe (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .i_hs     (hs_in),
        .o_strobe (w_strobe),
        .o_hsync  (w_hsync)
    );

    // Edge qualifiers are only meaningful in a strobe cycle.
    assign w_rise       = ~r_vbl_d & vblank_in;
    assign w_fall       = r_vbl_d & ~vblank_in;
    assign w_vs_start   = r_valid ? r_vs_start : L_DEF_START;
    assign w_line_inc   = (r_line_cnt >= L_MAX) ? L_MAX : r_line_cnt + 1'b1;
    assign w_timeout    = (w_line_inc == L_MAX);
    // In FREE the line counter is reused as the free-run period phase.
    assign w_free_phase = (r_line_cnt >= L_MAX_M1) ? '0 : r_line_cnt + 1'b1;

    // Vblank line counter: cleared on rise, saturating count while vblank is high.
    always_comb begin
        w_vblcnt_nxt = r_vblcnt;
        if (w_rise) begin
            w_vblcnt_nxt = '0;
        end else if (vblank_in && (r_vblcnt != '1)) begin
            w_vblcnt_nxt = r_vblcnt + 1'b1;
        end
    end

    // Next state, line counter and vsync for the coming strobe.
    always_comb begin
        w_state_nxt  = r_state;
        w_line_nxt   = w_line_inc;
        w_vs_cnt_nxt = r_vs_cnt;
        if (w_rise) begin
            w_line_nxt = '0;
            if (w_vs_start == '0) begin
                w_state_nxt  = VS;
                w_vs_cnt_nxt = LINE_W'(1);
            end else begin
                w_state_nxt = WAIT;
            end
        end else if ((r_state != FREE) && w_timeout) begin
            w_state_nxt = FREE;
            w_line_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                WAIT: begin
                    if (w_fall) begin
                        w_state_nxt = IDLE;
                    end else if (w_vblcnt_nxt == w_vs_start) begin
                        w_state_nxt  = VS;
                        w_vs_cnt_nxt = LINE_W'(1);
                    end
                end
                VS: begin
                    if (w_fall) begin
                        w_state_nxt = IDLE;
                    end else if (r_vs_cnt >= L_VS_LINES) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_vs_cnt_nxt = r_vs_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (w_fall) begin
                        w_state_nxt = IDLE;
                    end
                end
                FREE: begin
                    w_line_nxt = w_free_phase;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
        w_vsync_nxt = (w_state_nxt == VS) ||
                      ((w_state_nxt == FREE) && (w_line_nxt < L_VS_LINES));
    end

    // Vblank measurement; vs_start is recomputed the cycle after each fall.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_vbl_d    <= 1'b0;
            r_vblcnt   <= '0;
            r_vbl_len  <= '0;
            r_vs_start <= L_DEF_START;
            r_valid    <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (r_upd) begin
                r_vs_start <= calc_vs_start(r_vbl_len, VS_LINES, VS_OFFSET);
            end
            if (w_strobe) begin
                r_vbl_d  <= vblank_in;
                r_vblcnt <= w_vblcnt_nxt;
                if (w_fall) begin
                    r_vbl_len <= (r_vblcnt == '1) ? r_vblcnt : r_vblcnt + 1'b1;
                    r_valid   <= 1'b1;
                    r_upd     <= 1'b1;
                end
            end
        end
    end

    // Sync state machine and registered outputs, advanced on line strobes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= IDLE;
            r_line_cnt  <= '0;
            r_vs_cnt    <= '0;
            r_vsync     <= 1'b0;
            r_sync_lost <= 1'b0;
        end else if (w_strobe) begin
            r_state     <= w_state_nxt;
            r_line_cnt  <= w_line_nxt;
            r_vs_cnt    <= w_vs_cnt_nxt;
            r_vsync     <= w_vsync_nxt;
            r_sync_lost <= (w_state_nxt == FREE);
        end
    end

    assign hsync     = w_hsync;
    assign vsync     = r_vsync;
    assign vbl_len   = r_vbl_len;
    assign sync_lost = r_sync_lost;

`ifdef VBLANK_SYNC_STATS_EN
    logic [LINE_W-1:0] r_fcnt;
    logic [LINE_W-1:0] w_fcnt_inc;
    logic [LINE_W-1:0] r_frame_lines;
    logic              r_pal;

    assign w_fcnt_inc = (r_fcnt == '1) ? r_fcnt : r_fcnt + 1'b1;

    // Strobes between consecutive vblank rises, latched at each rise.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_fcnt        <= '0;
            r_frame_lines <= '0;
            r_pal         <= 1'b0;
        end else if (w_strobe) begin
            if (w_rise) begin
                r_fcnt        <= '0;
                r_frame_lines <= w_fcnt_inc;
                r_pal         <= (w_fcnt_inc > LINE_W'(PAL_THRESH));
            end else begin
                r_fcnt <= w_fcnt_inc;
            end
        end
    end

    assign frame_lines = r_frame_lines;
    assign pal_frame   = r_pal;
`endif

endmodule
